// File: rtl/mul_final_stage_if.sv
// Bus bundle for mul_final_stage: carry-save rows and sideband in, product out.
// Latency: none (wires only); clk_i/rst_i stay plain ports on the module.
// Backpressure: ready_i from downstream, stall_o back to upstream.
interface mul_final_stage_if #(parameter int WIDTH = 32);
  logic                 valid_i;
  logic [2*WIDTH-1:0]   row0_i;
  logic [2*WIDTH-1:0]   row1_i;
  logic [2*WIDTH-1:0]   row2_i;
  logic [2*WIDTH-1:0]   row3_i;
  logic                 sel_hi_i;
  logic [4:0]           tag_i;
  logic                 ready_i;
  logic                 valid_o;
  logic [WIDTH-1:0]     result_o;
  logic [2*WIDTH-1:0]   prod_o;
  logic [4:0]           tag_o;
  logic                 stall_o;
  logic                 err_o;

  // Upstream/downstream side: drives rows, sideband and ready.
  modport master (
    output valid_i, row0_i, row1_i, row2_i, row3_i, sel_hi_i, tag_i, ready_i,
    input  valid_o, result_o, prod_o, tag_o, stall_o, err_o
  );

  // Multiplier final stage side.
  modport slave (
    input  valid_i, row0_i, row1_i, row2_i, row3_i, sel_hi_i, tag_i, ready_i,
    output valid_o, result_o, prod_o, tag_o, stall_o, err_o
  );
endinterface

// File: rtl/mul_final_stage.sv
// Multiplier final stage: 4:2 compress four carry-save rows, then split 32+32 carry-propagate add.
// Latency: 3 cycles valid_i -> valid_o; one product per cycle. Optional skid FIFO: MUL_FINAL_SKID_EN.
// Backpressure: valid_o & ~ready_i freezes every stage; input presented while stall_o is high is dropped and err_o sticks.
module mul_final_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mul_final_stage_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  typedef struct packed {
    logic [W2-1:0] row0;
    logic [W2-1:0] row1;
    logic [W2-1:0] row2;
    logic [W2-1:0] row3;
    logic          sel_hi;
    logic [4:0]    tag;
  } in_t;

  typedef struct packed {
    logic [W2-1:0] s;
    logic [W2-1:0] c;
    logic          sel_hi;
    logic [4:0]    tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic             c32;
    logic [WIDTH-1:0] s_hi;
    logic [WIDTH-1:0] c_hi;
    logic             sel_hi;
    logic [4:0]       tag;
  } s2_t;

  typedef struct packed {
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] result;
    logic [4:0]       tag;
  } s3_t;

  logic          freeze;
  logic          adv;
  in_t           in_dat;
  in_t           s1_src;
  logic          s1_src_vld;
  logic          in_drop;

  logic [W2-1:0] csa0_s;
  logic [W2-1:0] csa0_c;
  logic [W2-1:0] csa1_s;
  logic [W2-1:0] csa1_c;
  logic [WIDTH:0]   lo_sum;
  logic [WIDTH-1:0] hi_sum;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic v1_d, v1_q;
  logic v2_d, v2_q;
  logic vo_d, vo_q;
  logic err_d, err_q;

  // A held output word freezes the whole pipe, bubbles included, so order is preserved.
  assign freeze = vo_q & ~bus.ready_i;
  assign adv    = ~freeze;

  assign in_dat = {bus.row0_i, bus.row1_i, bus.row2_i, bus.row3_i, bus.sel_hi_i, bus.tag_i};

`ifdef MUL_FINAL_SKID_EN
  in_t  [1:0] fifo_d, fifo_q;
  logic [1:0] cnt_d, cnt_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);
  // Head goes to S1 first; a new input only bypasses the FIFO when it is empty and the pipe moves.
  assign fifo_pop   = adv & ~fifo_empty;
  assign fifo_push  = bus.valid_i & ~fifo_full & ~(adv & fifo_empty);
  assign s1_src     = fifo_empty ? in_dat : fifo_q[0];
  assign s1_src_vld = fifo_empty ? bus.valid_i : 1'b1;
  assign in_drop    = bus.valid_i & fifo_full;
  assign bus.stall_o = fifo_full;

  // Two-entry shift FIFO: entry 0 is always the head.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    if (fifo_pop) begin
      fifo_d[0] = fifo_q[1];
    end
    if (fifo_push) begin
      fifo_d[cnt_q[0] & ~fifo_pop] = in_dat;
    end
  end

  // FIFO storage; reset empties it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      fifo_q <= fifo_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign s1_src      = in_dat;
  assign s1_src_vld  = bus.valid_i & ~freeze;
  assign in_drop     = bus.valid_i & freeze;
  assign bus.stall_o = freeze;
`endif

  // 4:2 compressor as two 3:2 layers; carry bits shifted out of the top are discarded.
  assign csa0_s = s1_src.row0 ^ s1_src.row1 ^ s1_src.row2;
  assign csa0_c = ((s1_src.row0 & s1_src.row1) | (s1_src.row0 & s1_src.row2) |
                   (s1_src.row1 & s1_src.row2)) << 1;
  assign csa1_s = csa0_s ^ csa0_c ^ s1_src.row3;
  assign csa1_c = ((csa0_s & csa0_c) | (csa0_s & s1_src.row3) |
                   (csa0_c & s1_src.row3)) << 1;

  // Low half add in S2, high half plus carry-in in S3: one W-bit add per stage.
  assign lo_sum = {1'b0, s1_q.s[WIDTH-1:0]} + {1'b0, s1_q.c[WIDTH-1:0]};
  assign hi_sum = s2_q.s_hi + s2_q.c_hi + {{(WIDTH-1){1'b0}}, s2_q.c32};

  // S1 next state: capture compressed rows when the pipe advances.
  always_comb begin
    s1_d = s1_q;
    v1_d = v1_q;
    if (adv) begin
      v1_d = s1_src_vld;
      if (s1_src_vld) begin
        s1_d = {csa1_s, csa1_c, s1_src.sel_hi, s1_src.tag};
      end
    end
  end

  // S2 next state: resolve low word, carry the high halves through untouched.
  always_comb begin
    s2_d = s2_q;
    v2_d = v2_q;
    if (adv) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d = {lo_sum[WIDTH-1:0], lo_sum[WIDTH], s1_q.s[W2-1:WIDTH], s1_q.c[W2-1:WIDTH],
                s1_q.sel_hi, s1_q.tag};
      end
    end
  end

  // S3 next state: finish the high word and pick the returned half.
  always_comb begin
    s3_d = s3_q;
    vo_d = vo_q;
    if (adv) begin
      vo_d = v2_q;
      if (v2_q) begin
        s3_d = {hi_sum, s2_q.lo, (s2_q.sel_hi ? hi_sum : s2_q.lo), s2_q.tag};
      end
    end
  end

  // Dropped-input flag stays set until reset.
  always_comb begin
    err_d = err_q | in_drop;
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      vo_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      vo_q  <= vo_d;
      err_q <= err_d;
    end
  end

  assign bus.valid_o  = vo_q;
  assign bus.prod_o   = s3_q.prod;
  assign bus.result_o = s3_q.result;
  assign bus.tag_o    = s3_q.tag;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_mul_final_stage.sv
// Bench for mul_final_stage: directed vectors, freeze/hold, drop, reset and random traffic.
// Expected products come from an arithmetic model pushed to a queue at acceptance.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_mul_final_stage;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [63:0] prod;
    logic [31:0] result;
    logic [4:0]  tag;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk_i = ~clk_i;

  mul_final_stage_if #(.WIDTH(WIDTH)) bus ();

  mul_final_stage #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic exp_t model(input logic [63:0] r0, input logic [63:0] r1,
                                 input logic [63:0] r2, input logic [63:0] r3,
                                 input logic sel, input logic [4:0] tag);
    exp_t        e;
    logic [63:0] p;
    p        = r0 + r1 + r2 + r3;
    e.prod   = p;
    e.result = sel ? p[63:32] : p[31:0];
    e.tag    = tag;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [63:0] r0, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [63:0] r3,
                       input logic sel, input logic [4:0] tag);
    bus.valid_i  = v;
    bus.row0_i   = r0;
    bus.row1_i   = r1;
    bus.row2_i   = r2;
    bus.row3_i   = r3;
    bus.sel_hi_i = sel;
    bus.tag_i    = tag;
  endtask

  // One clock: record acceptance into the scoreboard, report whether an output transferred.
  task automatic tick(output logic xfer, output exp_t got);
    #1;
    if (bus.valid_i === 1'b1 && bus.stall_o === 1'b0 && rst_i === 1'b0)
      exp_q.push_back(model(bus.row0_i, bus.row1_i, bus.row2_i, bus.row3_i, bus.sel_hi_i, bus.tag_i));
    xfer = (bus.valid_o === 1'b1) && (bus.ready_i === 1'b1) && (rst_i === 1'b0);
    got  = {bus.prod_o, bus.result_o, bus.tag_o};
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    logic x;
    exp_t g;
    rst_i = 1'b1;
    bus.ready_i = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    repeat (3) tick(x, g);
    rst_i = 1'b0;
    #1;
    compared++; if (bus.valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    compared++; if (bus.stall_o !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b want=0", bus.stall_o); end
    compared++; if (bus.err_o !== 1'b0) begin mismatched++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
    compared++; if (bus.prod_o !== 64'd0) begin mismatched++; $display("FAIL reset_prod got=%h want=0", bus.prod_o); end
    compared++; if (bus.result_o !== 32'd0) begin mismatched++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
    compared++; if (bus.tag_o !== 5'd0) begin mismatched++; $display("FAIL reset_tag got=%0d want=0", bus.tag_o); end
    bus.ready_i = 1'b1;
  endtask

  task automatic test_basic;
    logic [63:0] r0, r1, r2, r3, wp;
    logic [31:0] wr;
    logic        sel, x;
    logic [4:0]  tg;
    exp_t        g, e;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin r0 = 64'd5; r1 = 64'd7; r2 = 64'd0; r3 = 64'd0; sel = 1'b0; tg = 5'd3;
                  wp = 64'd12; wr = 32'd12; end
        1: begin r0 = 64'hFFFF_FFFF; r1 = 64'd1; r2 = 64'd0; r3 = 64'd0; sel = 1'b1; tg = 5'd7;
                  wp = 64'h1_0000_0000; wr = 32'd1; end
        default: begin r0 = '1; r1 = '1; r2 = 64'd2; r3 = 64'd0; sel = 1'b0; tg = 5'd21;
                  wp = 64'd0; wr = 32'd0; end
      endcase
      bus.ready_i = 1'b1;
      drive(1'b1, r0, r1, r2, r3, sel, tg);
      tick(x, g);
      drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 10) begin
        tick(x, g);
        lat++;
      end
      compared++; if (lat !== 3) begin mismatched++; $display("FAIL basic%0d_latency got=%0d want=3", i, lat); end
      compared++; if (bus.prod_o !== wp) begin mismatched++; $display("FAIL basic%0d_prod got=%h want=%h", i, bus.prod_o, wp); end
      compared++; if (bus.result_o !== wr) begin mismatched++; $display("FAIL basic%0d_result got=%h want=%h", i, bus.result_o, wr); end
      compared++; if (bus.tag_o !== tg) begin mismatched++; $display("FAIL basic%0d_tag got=%0d want=%0d", i, bus.tag_o, tg); end
      compared++; if (bus.err_o !== 1'b0) begin mismatched++; $display("FAIL basic%0d_err got=%b want=0", i, bus.err_o); end
      tick(x, g);
      compared++;
      if (!x || exp_q.size() == 0) begin
        mismatched++; $display("FAIL basic%0d_xfer got xfer=%b queued=%0d want xfer=1", i, x, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL basic%0d_sb got=%h want=%h", i, g, e); end
      end
      compared++; if (bus.valid_o !== 1'b0) begin mismatched++; $display("FAIL basic%0d_deassert got=%b want=0", i, bus.valid_o); end
    end
  endtask

  task automatic test_back_to_back;
    logic x, seen;
    exp_t g, e;
    int   sent, recvd, hold;
    sent = 0; recvd = 0; hold = 0; seen = 1'b0;
    for (int c = 0; c < 40 && recvd < 4; c++) begin
      if (!seen && bus.valid_o === 1'b1) begin seen = 1'b1; hold = 3; end
      bus.ready_i = (hold == 0);
      #1;
      if (hold > 0) begin
        compared++; if (bus.valid_o !== 1'b1) begin mismatched++; $display("FAIL b2b_hold_valid got=%b want=1", bus.valid_o); end
        compared++; if (bus.stall_o !== 1'b1) begin mismatched++; $display("FAIL b2b_hold_stall got=%b want=1", bus.stall_o); end
        compared++; if (bus.result_o !== 32'd1) begin mismatched++; $display("FAIL b2b_hold_result got=%h want=1", bus.result_o); end
      end
      if (sent < 4 && bus.stall_o === 1'b0) begin
        drive(1'b1, 64'(sent + 1), '0, '0, '0, 1'b0, 5'(sent + 8));
        sent++;
      end else begin
        drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
      end
      tick(x, g);
      if (hold > 0) hold--;
      if (x) begin
        recvd++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL b2b_unexpected got=%h", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin mismatched++; $display("FAIL b2b_sb got=%h want=%h", g, e); end
        end
      end
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    bus.ready_i = 1'b1;
    compared++; if (recvd !== 4) begin mismatched++; $display("FAIL b2b_count got=%0d want=4", recvd); end
  endtask

  task automatic test_drop;
    logic x;
    exp_t g, e;
    int   c;
    bus.ready_i = 1'b1;
    drive(1'b1, 64'd100, 64'd1, '0, '0, 1'b0, 5'd17);
    tick(x, g);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    c = 0;
    while (bus.valid_o !== 1'b1 && c < 10) begin tick(x, g); c++; end
    compared++; if (bus.valid_o !== 1'b1) begin mismatched++; $display("FAIL drop_first got valid=%b want=1", bus.valid_o); end
    bus.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'(200 + k), '0, '0, '0, 1'b1, 5'(k + 24));
      tick(x, g);
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    compared++; if (bus.err_o !== 1'b1) begin mismatched++; $display("FAIL drop_err got=%b want=1", bus.err_o); end
    bus.ready_i = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(x, g);
      if (x) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL drop_unexpected got=%h", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin mismatched++; $display("FAIL drop_sb got=%h want=%h", g, e); end
        end
      end
    end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL drop_missing got=%0d queued want=0", exp_q.size()); end
    compared++; if (bus.err_o !== 1'b1) begin mismatched++; $display("FAIL drop_err_sticky got=%b want=1", bus.err_o); end
    rst_i = 1'b1;
    tick(x, g);
    rst_i = 1'b0;
    compared++; if (bus.err_o !== 1'b0) begin mismatched++; $display("FAIL drop_err_clear got=%b want=0", bus.err_o); end
  endtask

  task automatic test_reset_midflight;
    logic x;
    exp_t g, e;
    int   lat, spurious;
    bus.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'(300 + k), 64'd5, '0, '0, 1'b0, 5'(k + 1));
      tick(x, g);
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    rst_i = 1'b1;
    tick(x, g);
    rst_i = 1'b0;
    exp_q.delete();
    compared++; if (bus.valid_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid got=%b want=0", bus.valid_o); end
    compared++; if (bus.prod_o !== 64'd0) begin mismatched++; $display("FAIL rstmid_prod got=%h want=0", bus.prod_o); end
    compared++; if (bus.result_o !== 32'd0) begin mismatched++; $display("FAIL rstmid_result got=%h want=0", bus.result_o); end
    compared++; if (bus.tag_o !== 5'd0) begin mismatched++; $display("FAIL rstmid_tag got=%0d want=0", bus.tag_o); end
    compared++; if (bus.stall_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_stall got=%b want=0", bus.stall_o); end
    bus.ready_i = 1'b1;
    spurious = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.valid_o !== 1'b0) spurious++;
      tick(x, g);
    end
    compared++; if (spurious !== 0) begin mismatched++; $display("FAIL rstmid_ghost got=%0d cycles valid want=0", spurious); end
    drive(1'b1, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0001, '0, '0, 1'b1, 5'd9);
    tick(x, g);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    lat = 1;
    while (bus.valid_o !== 1'b1 && lat < 10) begin tick(x, g); lat++; end
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL rstmid_latency got=%0d want=3", lat); end
    compared++; if (bus.result_o !== 32'd5) begin mismatched++; $display("FAIL rstmid_result_new got=%h want=5", bus.result_o); end
    tick(x, g);
    compared++;
    if (!x || exp_q.size() == 0) begin
      mismatched++; $display("FAIL rstmid_xfer got xfer=%b queued=%0d want xfer=1", x, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin mismatched++; $display("FAIL rstmid_sb got=%h want=%h", g, e); end
    end
  endtask

  task automatic test_random;
    logic x;
    exp_t g, e;
    for (int c = 0; c < 80; c++) begin
      bus.ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (c < 60 && bus.stall_o === 1'b0 && $urandom_range(0, 1) == 1)
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom), 5'($urandom));
      else
        drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
      if (c >= 60) bus.ready_i = 1'b1;
      tick(x, g);
      if (x) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL rand_unexpected got=%h", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin mismatched++; $display("FAIL rand_sb got=%h want=%h", g, e); end
        end
      end
    end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL rand_missing got=%0d queued want=0", exp_q.size()); end
    compared++; if (bus.err_o !== 1'b0) begin mismatched++; $display("FAIL rand_err got=%b want=0", bus.err_o); end
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, '0, 1'b0, 5'd0);
    bus.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
